// File: rtl/instr_aligner_if.sv
// Fetch-to-decode handshake bundle for the instruction aligner.
// The aligner uses slave; the fetch/decode environment uses master.
interface instr_aligner_if;
    logic        in_valid;
    logic [31:0] in_rdata;
    logic        in_ready;
    logic        branch;
    logic [31:0] branch_addr;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        out_is_compressed;
    logic        out_ready;

    modport slave (
        input  in_valid,
        input  in_rdata,
        input  branch,
        input  branch_addr,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_instr,
        output out_addr,
        output out_is_compressed
    );

    modport master (
        output in_valid,
        output in_rdata,
        output branch,
        output branch_addr,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_instr,
        input  out_addr,
        input  out_is_compressed
    );
endinterface

// File: rtl/instr_aligner.sv
// Splits word-aligned fetch data into 16/32-bit RISC-V instructions,
// stitching 32-bit instructions that straddle a word boundary.
module instr_aligner #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
    input  logic           CLK,
    input  logic           RESET,
    instr_aligner_if.slave bus
);
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] STASH = 2'd1;
    localparam logic [1:0] SKIP  = 2'd2;

    logic [1:0]  state;
    logic [15:0] stash;
    logic [31:0] pc;
    logic        live;

    logic        out_valid;
    logic        in_ready;
    logic [31:0] out_instr;
    logic        word_c;
    logic        stash_c;
    logic        fire_in;
    logic        fire_out;
    logic        unused_bit0;

    assign word_c      = bus.in_rdata[1:0] != 2'b11;
    assign stash_c     = stash[1:0] != 2'b11;
    assign unused_bit0 = bus.branch_addr[0];

    // live holds outputs quiet until the first edge after reset release
    always_comb begin
        out_valid = 1'b0;
        in_ready  = 1'b0;
        out_instr = 32'h0;
        if (live) begin
            if (bus.branch) begin
                in_ready = 1'b1;
            end else begin
                case (state)
                    EMPTY: begin
                        out_valid = bus.in_valid;
                        in_ready  = bus.out_ready;
                        out_instr = word_c
                            ? {16'h0, bus.in_rdata[15:0]}
                            : bus.in_rdata;
                    end
                    STASH: begin
                        if (stash_c) begin
                            out_valid = 1'b1;
                            out_instr = {16'h0, stash};
                        end else begin
                            out_valid = bus.in_valid;
                            in_ready  = bus.out_ready;
                            out_instr = {bus.in_rdata[15:0], stash};
                        end
                    end
                    SKIP: begin
                        in_ready = 1'b1;
                    end
                    default: begin
                        in_ready = 1'b0;
                    end
                endcase
            end
        end
    end

    assign fire_in  = bus.in_valid && in_ready;
    assign fire_out = out_valid && bus.out_ready;

    assign bus.out_valid         = out_valid;
    assign bus.in_ready          = in_ready;
    assign bus.out_instr         = out_instr;
    assign bus.out_addr          = pc;
    assign bus.out_is_compressed = out_instr[1:0] != 2'b11;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= EMPTY;
            stash <= 16'h0;
            pc    <= BOOT_ADDR;
            live  <= 1'b0;
        end else begin
            live <= 1'b1;
            if (live) begin
                if (bus.branch) begin
                    pc    <= {bus.branch_addr[31:1], 1'b0};
                    stash <= 16'h0;
                    state <= bus.branch_addr[1] ? SKIP : EMPTY;
                end else begin
                    case (state)
                        EMPTY: begin
                            if (fire_out && word_c) begin
                                stash <= bus.in_rdata[31:16];
                                pc    <= pc + 32'd2;
                                state <= STASH;
                            end else if (fire_out) begin
                                pc <= pc + 32'd4;
                            end
                        end
                        STASH: begin
                            if (fire_out && stash_c) begin
                                pc    <= pc + 32'd2;
                                state <= EMPTY;
                            end else if (fire_out) begin
                                stash <= bus.in_rdata[31:16];
                                pc    <= pc + 32'd4;
                            end
                        end
                        SKIP: begin
                            if (fire_in) begin
                                stash <= bus.in_rdata[31:16];
                                state <= STASH;
                            end
                        end
                        default: begin
                            state <= EMPTY;
                        end
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_instr_aligner.sv
// Directed vector table plus randomized traffic checked against a
// halfword-queue model of the aligner.
module tb_instr_aligner;
    logic CLK = 1'b0;
    logic RESET = 1'b0;
    always #5 CLK = ~CLK;

    instr_aligner_if bus();

    instr_aligner #(.BOOT_ADDR(32'h0000_0080)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        iv;
        logic [31:0] rd;
        logic        ordy;
        logic        br;
        logic [31:0] ba;
        logic        eov;
        logic        eir;
        logic [31:0] ei;
        logic [31:0] ea;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        logic iv, logic [31:0] rd, logic ordy,
        logic br, logic [31:0] ba,
        logic eov, logic eir,
        logic [31:0] ei, logic [31:0] ea);
        vec_t v;
        v.iv = iv; v.rd = rd; v.ordy = ordy;
        v.br = br; v.ba = ba;
        v.eov = eov; v.eir = eir;
        v.ei = ei; v.ea = ea;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act,
                       logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h",
                     name, act, exp);
        end
    endtask

    task automatic drive(logic iv, logic [31:0] rd,
                         logic ordy, logic br,
                         logic [31:0] ba);
        bus.in_valid    = iv;
        bus.in_rdata    = rd;
        bus.out_ready   = ordy;
        bus.branch      = br;
        bus.branch_addr = ba;
    endtask

    // Reference: pending halfwords in a queue, pc, and a
    // flag saying the low half of the next word is dropped.
    logic [15:0] hq[$];
    logic [31:0] m_pc;
    bit          m_skip;

    task automatic model(
        input  logic iv, input logic [31:0] rd,
        input  logic ordy, input logic br,
        input  logic [31:0] ba,
        output logic ov, output logic ir,
        output logic [31:0] ins);
        logic [15:0] v[$];
        int used;
        v = hq;
        if (iv && !m_skip) begin
            v.push_back(rd[15:0]);
            v.push_back(rd[31:16]);
        end
        used = 0;
        ins  = 32'h0;
        if (!br && !m_skip && v.size() > 0) begin
            if (v[0][1:0] != 2'b11) begin
                used = 1;
                ins  = {16'h0, v[0]};
            end else if (v.size() >= 2) begin
                used = 2;
                ins  = {v[1], v[0]};
            end
        end
        ov = used != 0;
        if (br || m_skip)
            ir = 1'b1;
        else if (hq.size() > 0 && hq[0][1:0] != 2'b11)
            ir = 1'b0;
        else
            ir = ordy;
        if (br) begin
            hq.delete();
            m_pc   = {ba[31:1], 1'b0};
            m_skip = ba[1];
        end else if (m_skip) begin
            if (iv) begin
                hq.delete();
                hq.push_back(rd[31:16]);
                m_skip = 1'b0;
            end
        end else if (ov && ordy) begin
            if (ir && iv) hq = v;
            repeat (used) void'(hq.pop_front());
            m_pc = m_pc + 32'(2 * used);
        end
    endtask

    initial begin
        logic        m_ov, m_ir;
        logic [31:0] m_ins, rd, ba;
        logic [15:0] lo, hi;

        tbl.push_back(mk(0, 32'h0,        1, 0, 0,
                         0, 1, 32'h0,        32'h80));
        tbl.push_back(mk(1, 32'h00A00093, 1, 0, 0,
                         1, 1, 32'h00A00093, 32'h80));
        tbl.push_back(mk(0, 32'h0,        1, 0, 0,
                         0, 1, 32'h0,        32'h84));
        tbl.push_back(mk(1, 32'hDEADBEEF, 1, 1, 32'h80,
                         0, 1, 32'h0,        32'h84));
        tbl.push_back(mk(1, 32'h45014585, 1, 0, 0,
                         1, 1, 32'h00004585, 32'h80));
        tbl.push_back(mk(1, 32'h12345678, 1, 0, 0,
                         1, 0, 32'h00004501, 32'h82));
        tbl.push_back(mk(1, 32'h00934585, 1, 0, 0,
                         1, 1, 32'h00004585, 32'h84));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(1, 32'hBEEF00A0, 0, 0, 0,
                             1, 0, 32'h00A00093, 32'h86));
        tbl.push_back(mk(1, 32'hBEEF00A0, 1, 0, 0,
                         1, 1, 32'h00A00093, 32'h86));
        tbl.push_back(mk(0, 32'h0,        1, 0, 0,
                         0, 1, 32'h0,        32'h8A));
        tbl.push_back(mk(1, 32'h00000001, 1, 0, 0,
                         1, 1, 32'h0001BEEF, 32'h8A));
        tbl.push_back(mk(0, 32'h0,        1, 0, 0,
                         1, 0, 32'h00000000, 32'h8E));
        tbl.push_back(mk(0, 32'h0,        1, 1, 32'h102,
                         0, 1, 32'h0,        32'h90));
        tbl.push_back(mk(1, 32'h00930001, 1, 0, 0,
                         0, 1, 32'h0,        32'h102));
        tbl.push_back(mk(1, 32'h123400A0, 1, 0, 0,
                         1, 1, 32'h00A00093, 32'h102));
        tbl.push_back(mk(0, 32'h0,        1, 0, 0,
                         1, 0, 32'h00001234, 32'h106));
        tbl.push_back(mk(1, 32'h00934585, 1, 0, 0,
                         1, 1, 32'h00004585, 32'h108));
        tbl.push_back(mk(1, 32'hBEEF00A0, 1, 1, 32'h200,
                         0, 1, 32'h0,        32'h10A));
        tbl.push_back(mk(1, 32'h00A00093, 1, 0, 0,
                         1, 1, 32'h00A00093, 32'h200));
        tbl.push_back(mk(0, 32'h0,        1, 0, 0,
                         0, 1, 32'h0,        32'h204));
        tbl.push_back(mk(0, 32'h0,        1, 1, 32'hFFFFFFFD,
                         0, 1, 32'h0,        32'h204));
        tbl.push_back(mk(1, 32'h00A00093, 1, 0, 0,
                         1, 1, 32'h00A00093, 32'hFFFFFFFC));
        tbl.push_back(mk(0, 32'h0,        1, 0, 0,
                         0, 1, 32'h0,        32'h0));

        drive(1, 32'h00A00093, 1, 0, 0);
        #12;
        chk("rst_out_valid", {31'h0, bus.out_valid}, 0);
        chk("rst_out_addr", bus.out_addr, 32'h80);
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        chk("release_out_valid", {31'h0, bus.out_valid}, 0);
        @(posedge CLK);

        foreach (tbl[i]) begin
            @(negedge CLK);
            drive(tbl[i].iv, tbl[i].rd, tbl[i].ordy,
                  tbl[i].br, tbl[i].ba);
            #1;
            chk($sformatf("v%0d_out_valid", i),
                {31'h0, bus.out_valid}, {31'h0, tbl[i].eov});
            chk($sformatf("v%0d_in_ready", i),
                {31'h0, bus.in_ready}, {31'h0, tbl[i].eir});
            chk($sformatf("v%0d_out_addr", i),
                bus.out_addr, tbl[i].ea);
            if (tbl[i].eov) begin
                chk($sformatf("v%0d_out_instr", i),
                    bus.out_instr, tbl[i].ei);
                chk($sformatf("v%0d_is_c", i),
                    {31'h0, bus.out_is_compressed},
                    {31'h0, tbl[i].ei[1:0] != 2'b11});
            end
        end

        // Reset while a 32-bit instruction is half assembled
        @(negedge CLK);
        drive(1, 32'h00934585, 1, 0, 0);
        @(negedge CLK);
        RESET = 1'b0;
        drive(1, 32'h00A00093, 1, 0, 0);
        #1;
        chk("midrst_out_valid", {31'h0, bus.out_valid}, 0);
        chk("midrst_out_addr", bus.out_addr, 32'h80);
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        #1;
        chk("midrst_instr", bus.out_instr, 32'h00A00093);
        chk("midrst_valid", {31'h0, bus.out_valid}, 1);
        chk("midrst_addr", bus.out_addr, 32'h80);
        @(posedge CLK);

        hq.delete();
        m_pc   = 32'h84;
        m_skip = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge CLK);
            lo = 16'($urandom);
            hi = 16'($urandom);
            if ($urandom_range(1, 0) == 1) lo[1:0] = 2'b11;
            if ($urandom_range(1, 0) == 1) hi[1:0] = 2'b11;
            rd = {hi, lo};
            ba = $urandom;
            if ($urandom_range(3, 0) == 0)
                ba = 32'hFFFFFFF0 | {28'h0, ba[3:0]};
            drive($urandom_range(9, 0) < 7, rd,
                  $urandom_range(9, 0) < 7,
                  $urandom_range(11, 0) == 0, ba);
            #1;
            chk("rnd_out_addr", bus.out_addr, m_pc);
            model(bus.in_valid, bus.in_rdata,
                  bus.out_ready, bus.branch,
                  bus.branch_addr, m_ov, m_ir, m_ins);
            chk("rnd_out_valid", {31'h0, bus.out_valid},
                {31'h0, m_ov});
            chk("rnd_in_ready", {31'h0, bus.in_ready},
                {31'h0, m_ir});
            if (m_ov) begin
                chk("rnd_out_instr", bus.out_instr, m_ins);
                chk("rnd_is_c", {31'h0, bus.out_is_compressed},
                    {31'h0, m_ins[1:0] != 2'b11});
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
